slot2gmii_tx: RTL

//  Transmit engine for one ethpipe port. Reads host-written frames from a TX slot

---
 rtl/slot2gmii_tx.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/slot2gmii_tx.sv
// Slot RAM to GMII transmit engine: walks length-prefixed frames in a TX slot and sends them with preamble/SFD and IFG.
// Optional macro TX_CRC_APPEND_EN: pad short frames to 60 bytes and append a CRC-32 FCS.
module slot2gmii_tx #(
    parameter int ADDR_W  = 14,
    parameter int MAX_LEN = 1518,
    parameter int IFG     = 12
) (
    input  logic              gmii_tx_clk,
    input  logic              sys_rst,
    input  logic              tx_start,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_err,
    output logic [15:0]       tx_frame_cnt,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [15:0]       ram_q,
    output logic [7:0]        gmii_txd,
    output logic              gmii_tx_en
);

    // HDR and HDRCHK of the next frame run inside the gap, so only IFG-2 dedicated gap cycles remain
    localparam int GAP_CYCLES = (IFG > 2) ? IFG - 2 : 0;
    localparam logic [17:0] SLOT_WORDS = 18'd1 << ADDR_W;

`ifdef TX_CRC_APPEND_EN
    typedef enum logic [2:0] {IDLE, HDR, HDRCHK, PRE, DATA, GAP, PAD, FCS} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, HDRCHK, PRE, DATA, GAP} state_t;
`endif

    state_t state, state_next, after_frame;

    logic [ADDR_W:0]   hdr_ptr;
    logic [ADDR_W-1:0] data_ptr;
    logic [15:0]       frame_len;
    logic [15:0]       byte_idx;
    logic [15:0]       byte_idx_inc;
    logic [2:0]        pre_cnt;
    logic [7:0]        gap_cnt;
    logic [7:0]        low_byte;
    logic [15:0]       hdr_len;
    logic [17:0]       hdr_end;
    logic              last_data;
    logic [7:0]        txd_next;
    logic              tx_en_next;
    logic              done_next;
    logic              err_next;

`ifdef TX_CRC_APPEND_EN
    logic [31:0] crc;
    logic [1:0]  fcs_idx;

    function automatic logic [31:0] crc_update(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction
`endif

    assign hdr_len      = {ram_q[7:0], ram_q[15:8]};
    assign hdr_end      = 18'(hdr_ptr) + 18'd1 + ((18'(hdr_len) + 18'd1) >> 1);
    assign byte_idx_inc = byte_idx + 16'd1;
    assign last_data    = (byte_idx_inc == frame_len);
    assign after_frame  = (GAP_CYCLES == 0) ? HDR : GAP;
    assign tx_busy      = (state != IDLE);

    always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        ram_rd_en  = 1'b0;
        ram_addr   = '0;
        txd_next   = 8'h00;
        tx_en_next = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: if (tx_start) state_next = HDR;
            HDR: begin
                if (hdr_ptr[ADDR_W]) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    ram_rd_en  = 1'b1;
                    ram_addr   = hdr_ptr[ADDR_W-1:0];
                    state_next = HDRCHK;
                end
            end
            HDRCHK: begin
                if (hdr_len == 16'd0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else if (hdr_len > 16'(MAX_LEN) || hdr_end > SLOT_WORDS) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = PRE;
                end
            end
            PRE: begin
                tx_en_next = 1'b1;
                if (pre_cnt == 3'd7) begin
                    txd_next   = 8'hD5;
                    ram_rd_en  = 1'b1;
                    ram_addr   = data_ptr;
                    state_next = DATA;
                end else begin
                    txd_next = 8'h55;
                end
            end
            DATA: begin
                // Even bytes come straight from the fresh word; odd bytes from the held low half
                tx_en_next = 1'b1;
                txd_next   = byte_idx[0] ? low_byte : ram_q[15:8];
                if (byte_idx[0] && !last_data) begin
                    ram_rd_en = 1'b1;
                    ram_addr  = data_ptr;
                end
                if (last_data) begin
`ifdef TX_CRC_APPEND_EN
                    state_next = (byte_idx_inc < 16'd60) ? PAD : FCS;
`else
                    state_next = after_frame;
`endif
                end
            end
`ifdef TX_CRC_APPEND_EN
            PAD: begin
                tx_en_next = 1'b1;
                if (byte_idx_inc == 16'd60) state_next = FCS;
            end
            FCS: begin
                tx_en_next = 1'b1;
                txd_next   = ~crc[{fcs_idx, 3'b000} +: 8];
                if (fcs_idx == 2'd3) state_next = after_frame;
            end
`endif
            GAP: if (gap_cnt == 8'(GAP_CYCLES - 1)) state_next = HDR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            gmii_txd     <= 8'h00;
            gmii_tx_en   <= 1'b0;
            tx_done      <= 1'b0;
            tx_err       <= 1'b0;
            tx_frame_cnt <= 16'h0000;
            hdr_ptr      <= '0;
            data_ptr     <= '0;
            frame_len    <= 16'h0000;
            byte_idx     <= 16'h0000;
            pre_cnt      <= 3'd0;
            gap_cnt      <= 8'd0;
            low_byte     <= 8'h00;
`ifdef TX_CRC_APPEND_EN
            crc          <= 32'hFFFFFFFF;
            fcs_idx      <= 2'd0;
`endif
        end else begin
            gmii_txd   <= txd_next;
            gmii_tx_en <= tx_en_next;
            tx_done    <= done_next;
            tx_err     <= err_next;
            // tx_en only ever falls at the end of a completed frame
            if (gmii_tx_en && !tx_en_next) tx_frame_cnt <= tx_frame_cnt + 16'd1;
            if (ram_rd_en && state != HDR) data_ptr <= data_ptr + 1'b1;
            case (state)
                IDLE: if (tx_start) hdr_ptr <= '0;
                HDRCHK: begin
                    frame_len <= hdr_len;
                    hdr_ptr   <= hdr_end[ADDR_W:0];
                    data_ptr  <= hdr_ptr[ADDR_W-1:0] + 1'b1;
                    pre_cnt   <= 3'd0;
                    byte_idx  <= 16'h0000;
                    gap_cnt   <= 8'd0;
`ifdef TX_CRC_APPEND_EN
                    crc       <= 32'hFFFFFFFF;
                    fcs_idx   <= 2'd0;
`endif
                end
                PRE: pre_cnt <= pre_cnt + 3'd1;
                DATA: begin
                    if (!byte_idx[0]) low_byte <= ram_q[7:0];
                    byte_idx <= byte_idx_inc;
`ifdef TX_CRC_APPEND_EN
                    crc <= crc_update(crc, txd_next);
`endif
                end
`ifdef TX_CRC_APPEND_EN
                PAD: begin
                    byte_idx <= byte_idx_inc;
                    crc      <= crc_update(crc, txd_next);
                end
                FCS: fcs_idx <= fcs_idx + 2'd1;
`endif
                GAP: gap_cnt <= gap_cnt + 8'd1;
                default: ;
            endcase
        end
    end

endmodule
